// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Multi-channel comparator duty-cycle meter. Each channel synchronises its
//   comparator output and measures the high time of each pulse in clk cycles.
//   It scales that time to an OUT_W-bit code and flags channels that have
//   stopped toggling.
//
//   Ports
//     clk         system clock
//     reset       synchronous, active-high; clears every register
//     cmp_in      [CH]         asynchronous comparator outputs, bit i = channel i
//     duty_out    [CH*OUT_W]   scaled codes, channel i = [i*OUT_W +: OUT_W]
//     duty_valid  [CH]         1-cycle pulse when a channel's duty_out slice updates
//     stuck       [CH]         level, channel has seen no edge for TIMEOUT_CYC cycles
//
//   Build option
//     PWM_DUTY_AVG_EN  when defined, each channel averages 2**AVG_LOG2 codes
//                      before updating duty_out. This adds one cycle of latency.
module pwm_duty_meter #(
    parameter int unsigned       CH          = 4,
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       OUT_W       = 8,
    parameter int unsigned       MUL_W       = 16,
    parameter logic [MUL_W-1:0]  SCALE_MUL   = MUL_W'(255),
    parameter int unsigned       SCALE_SHIFT = 8,
    parameter int unsigned       TIMEOUT_CYC = 65535,
    parameter int unsigned       AVG_LOG2    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       cmp_in,
    output logic [CH*OUT_W-1:0] duty_out,
    output logic [CH-1:0]       duty_valid,
    output logic [CH-1:0]       stuck
);

    localparam int unsigned      PROD_W   = CNT_W + MUL_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [OUT_W-1:0] CODE_MAX = '1;

    if (TIMEOUT_CYC > (2**CNT_W - 1) || AVG_LOG2 < 1) begin : g_param_check
        $error("pwm_duty_meter: TIMEOUT_CYC must fit in CNT_W bits and AVG_LOG2 must be >= 1");
    end

    // s and p are only meaningful once real input has crossed both synchronizer
    // stages and the prev register after reset. Until then, the reset zeros
    // would look like a genuine low level and arm a channel whose input is high.
    logic [1:0] warm;
    logic       live;

    always_ff @(posedge clk) begin
        if (reset)
            warm <= '0;
        else if (warm != 2'd3)
            warm <= warm + 2'd1;
    end

    assign live = (warm == 2'd3);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             sync1, s, p;
        logic             rise, fall;
        logic             seen_low, counting, stuck_r;
        logic [CNT_W-1:0] high_cnt, idle_cnt, sample;
        logic             cap_valid, stuck_evt;
        logic [OUT_W-1:0] stuck_code;
        logic [PROD_W-1:0] product, scaled;
        logic [OUT_W-1:0] code;
        logic [OUT_W-1:0] dout;
        logic             dval;

        assign rise = live &  s & ~p;
        assign fall = live & ~s &  p;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1      <= 1'b0;
                s          <= 1'b0;
                p          <= 1'b0;
                seen_low   <= 1'b0;
                counting   <= 1'b0;
                stuck_r    <= 1'b0;
                high_cnt   <= '0;
                idle_cnt   <= '0;
                sample     <= '0;
                cap_valid  <= 1'b0;
                stuck_evt  <= 1'b0;
                stuck_code <= '0;
            end else begin
                sync1     <= cmp_in[i];
                s         <= sync1;
                p         <= s;
                cap_valid <= 1'b0;
                stuck_evt <= 1'b0;

                if (live && !s)
                    seen_low <= 1'b1;

                if (rise && seen_low) begin
                    high_cnt <= CNT_W'(1);
                    counting <= 1'b1;
                end else if (s && counting && high_cnt != CNT_MAX) begin
                    high_cnt <= high_cnt + CNT_W'(1);
                end

                if (fall && counting) begin
                    sample    <= high_cnt;
                    cap_valid <= 1'b1;
                    counting  <= 1'b0;
                end

                // Placed after the measurement logic so that stuck entry
                // overrides any counting update in the same cycle.
                if (rise || fall) begin
                    idle_cnt <= '0;
                    stuck_r  <= 1'b0;
                end else if (!stuck_r) begin
                    if (idle_cnt == TIMEOUT) begin
                        stuck_r    <= 1'b1;
                        stuck_evt  <= 1'b1;
                        stuck_code <= s ? CODE_MAX : '0;
                        counting   <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
            end
        end

        // Compute the full-width product, shift it, then saturate to the code range.
        assign product = PROD_W'(sample) * PROD_W'(SCALE_MUL);
        assign scaled  = product >> SCALE_SHIFT;
        assign code    = (scaled > PROD_W'(CODE_MAX)) ? CODE_MAX : scaled[OUT_W-1:0];

`ifdef PWM_DUTY_AVG_EN
        localparam int unsigned ACC_W = OUT_W + AVG_LOG2;
        logic [OUT_W-1:0]    code_r;
        logic                code_v;
        logic [ACC_W-1:0]    acc, acc_sum;
        logic [AVG_LOG2-1:0] n;

        assign acc_sum = acc + ACC_W'(code_r);

        always_ff @(posedge clk) begin
            if (reset) begin
                code_r <= '0;
                code_v <= 1'b0;
                acc    <= '0;
                n      <= '0;
                dout   <= '0;
                dval   <= 1'b0;
            end else begin
                code_r <= code;
                code_v <= cap_valid;
                dval   <= 1'b0;
                if (stuck_evt) begin
                    dout   <= stuck_code;
                    dval   <= 1'b1;
                    acc    <= '0;
                    n      <= '0;
                    code_v <= 1'b0;
                end else if (code_v) begin
                    if (n == '1) begin
                        dout <= acc_sum[ACC_W-1:AVG_LOG2];
                        dval <= 1'b1;
                        acc  <= '0;
                        n    <= '0;
                    end else begin
                        acc <= acc_sum;
                        n   <= n + AVG_LOG2'(1);
                    end
                end
            end
        end
`else
        always_ff @(posedge clk) begin
            if (reset) begin
                dout <= '0;
                dval <= 1'b0;
            end else begin
                dval <= cap_valid | stuck_evt;
                if (cap_valid)
                    dout <= code;
                else if (stuck_evt)
                    dout <= stuck_code;
            end
        end
`endif

        assign duty_out[i*OUT_W +: OUT_W] = dout;
        assign duty_valid[i]              = dval;
        assign stuck[i]                   = stuck_r;
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
module tb_pwm_duty_meter;

    localparam int CH    = 2;
    localparam int OUT_W = 8;
    localparam int TOUT  = 65535;
    localparam int MAXW  = 70000;
`ifdef PWM_DUTY_AVG_EN
    localparam bit AVG = 1'b1;
    localparam int LAT = 5;
`else
    localparam bit AVG = 1'b0;
    localparam int LAT = 4;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       cmp_in;
    logic [CH*OUT_W-1:0] duty_out;
    logic [CH-1:0]       duty_valid;
    logic [CH-1:0]       stuck;

    pwm_duty_meter #(.CH(CH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmp_in     (cmp_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int at;     // expected cycle of the valid pulse, -1 = any cycle
    } exp_t;

    exp_t          expq [CH][$];
    int            acc_m [CH];
    int            n_m [CH];
    logic [CH-1:0] wave [MAXW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int scale(input int h);
        int v;
        v = (h * 255) >> 8;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic void push_capture(input int ch, input int h, input int at);
        exp_t e;
        if (AVG) begin
            acc_m[ch] += scale(h);
            n_m[ch]++;
            if (n_m[ch] == 4) begin
                e.code = acc_m[ch] / 4;
                e.at   = at;
                expq[ch].push_back(e);
                acc_m[ch] = 0;
                n_m[ch]   = 0;
            end
        end else begin
            e.code = scale(h);
            e.at   = at;
            expq[ch].push_back(e);
        end
    endfunction

    function automatic void push_stuck(input int ch, input int code);
        exp_t e;
        acc_m[ch] = 0;
        n_m[ch]   = 0;
        e.code    = code;
        e.at      = -1;
        expq[ch].push_back(e);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            expq[c].delete();
            acc_m[c] = 0;
            n_m[c]   = 0;
        end
    endfunction

    function automatic void clear_wave(input int len);
        for (int t = 0; t < len; t++) wave[t] = '0;
    endfunction

    // Every high run in wave[] that ends inside the window is one pulse. Its
    // length is the expected count, and its falling position fixes the cycle
    // of the valid pulse.
    task automatic play(input int len);
        int base;
        int run;
        @(posedge clk); #1;
        base = cyc;
        for (int c = 0; c < CH; c++) begin
            run = 0;
            for (int t = 0; t < len; t++) begin
                if (wave[t][c]) run++;
                else begin
                    if (run > 0) push_capture(c, run, base + t + LAT);
                    run = 0;
                end
            end
        end
        for (int t = 0; t < len; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            cmp_in = wave[t];
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each valid pulse must match the next expected code, and the
    // expected cycle when one is known.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            if (duty_valid[c] !== 1'b0) begin
                if (expq[c].size() == 0) begin
                    chk($sformatf("unexpected_valid_ch%0d", c), 32'(duty_valid[c]), 32'd0);
                end else begin
                    e = expq[c].pop_front();
                    chk($sformatf("code_ch%0d", c), 32'(duty_out[c*OUT_W +: OUT_W]), 32'(e.code));
                    if (e.at >= 0)
                        chk($sformatf("valid_cycle_ch%0d", c), 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    initial begin
        int t;
        int h;
        int f;

        model_reset();
        cmp_in = '0;
        reset  = 1'b1;
        wait_cyc(3);
        chk("reset_duty_out", 32'(duty_out), 32'd0);
        chk("reset_valid", 32'(duty_valid), 32'd0);
        chk("reset_stuck", 32'(stuck), 32'd0);
        reset = 1'b0;
        wait_cyc(8);

        // Test 1: ch0 high 128 of a 256-cycle period.
        clear_wave(256);
        for (int k = 0; k < 128; k++) wave[k][0] = 1'b1;
        play(256);
        wait_cyc(10);
        if (!AVG) chk("t1_code", 32'(duty_out[7:0]), 32'd127);

        // Test 2: ch0 high 256, ch1 high 300, falling together.
        clear_wave(301);
        for (int k = 0; k < 300; k++) wave[k][1] = 1'b1;
        for (int k = 44; k < 300; k++) wave[k][0] = 1'b1;
        play(301);
        f = cyc;
        wait_cyc(4);
        @(negedge clk);
        if (!AVG) begin
            chk("t2_both_valid", 32'(duty_valid), 32'h3);
            chk("t2_cycle", 32'(cyc), 32'(f + 4));
        end
        wait_cyc(10);
        if (!AVG) chk("t2_codes", 32'(duty_out), 32'hFFFF);

        // Test 3: ch0 held high through reset release.
        cmp_in[0] = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(3);
        model_reset();
        reset = 1'b0;
        wait_cyc(40);
        clear_wave(100);
        for (int k = 20; k < 84; k++) wave[k][0] = 1'b1;
        play(100);
        wait_cyc(10);
        if (!AVG) chk("t3_code", 32'(duty_out[7:0]), 32'd63);

        // Test 4: ch1 held high past the timeout while ch0 keeps pulsing.
        push_stuck(1, 255);
        clear_wave(255 * 256);
        for (int p = 0; p < 255; p++) begin
            h = $urandom_range(1, 200);
            for (int k = 0; k < h; k++) wave[p*256 + 10 + k][0] = 1'b1;
        end
        for (int k = 0; k < 255 * 256; k++) wave[k][1] = 1'b1;
        play(255 * 256);
        chk("t4_not_yet_stuck", 32'(stuck[1]), 32'd0);
        clear_wave(300);
        h = $urandom_range(1, 200);
        for (int k = 0; k < h; k++) wave[10 + k][0] = 1'b1;
        for (int k = 0; k < 300; k++) wave[k][1] = 1'b1;
        play(300);
        chk("t4_stuck1", 32'(stuck[1]), 32'd1);
        chk("t4_stuck0", 32'(stuck[0]), 32'd0);
        wait_cyc(10);
        clear_wave(80);
        for (int k = 30; k < 62; k++) wave[k][1] = 1'b1;
        play(80);
        wait_cyc(10);
        chk("t4_stuck_cleared", 32'(stuck[1]), 32'd0);
        if (!AVG) chk("t4_code", 32'(duty_out[15:8]), 32'd31);

        // Randomised pulse trains on both channels.
        clear_wave(3000);
        for (int c = 0; c < CH; c++) begin
            t = $urandom_range(1, 40);
            while (t < 2980) begin
                h = $urandom_range(1, 300);
                for (int k = 0; k < h && t < 2980; k++) begin
                    wave[t][c] = 1'b1;
                    t++;
                end
                t += $urandom_range(1, 40);
            end
        end
        play(3000);
        wait_cyc(10);

        // Test 5: reset in the middle of a ch0 pulse.
        cmp_in[0] = 1'b1;
        wait_cyc(100);
        reset = 1'b1;
        wait_cyc(1);
        model_reset();
        chk("t5_duty_out", 32'(duty_out), 32'd0);
        chk("t5_valid", 32'(duty_valid), 32'd0);
        chk("t5_stuck", 32'(stuck), 32'd0);
        reset = 1'b0;
        wait_cyc(50);
        cmp_in[0] = 1'b0;
        wait_cyc(20);

`ifdef PWM_DUTY_AVG_EN
        // Test 6: average of four captures.
        reset = 1'b1;
        wait_cyc(2);
        model_reset();
        reset = 1'b0;
        wait_cyc(8);
        clear_wave(1024);
        for (int p = 0; p < 4; p++) begin
            h = (p < 2) ? 100 : 104;
            for (int k = 0; k < h; k++) wave[p*256 + 20 + k][0] = 1'b1;
        end
        play(1024);
        wait_cyc(10);
        chk("t6_avg_code", 32'(duty_out[7:0]), 32'd101);
`endif

        wait_cyc(10);
        for (int c = 0; c < CH; c++)
            chk($sformatf("pending_ch%0d", c), 32'(expq[c].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
